// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates ICache fetches and LSB loads/stores onto one
// byte-wide RAM/IO port, serialising each access into little-endian bytes.
module mem_ctrl #(
  parameter logic [1:0] IO_ADDR_BITS = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        clear,
  input  logic        if_enable,
  input  logic [31:0] if_addr,
  output logic [31:0] if_data,
  output logic        if_valid,
  input  logic        ls_enable,
  input  logic        ls_wr,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic [31:0] ls_rdata,
  output logic        ls_valid
);

  typedef enum logic [2:0] {StIdle, StCool, StIfetch, StLoad, StStore} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  num_q, num_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d;
  logic        if_valid_q, if_valid_d;
  logic        ls_valid_q, ls_valid_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] ls_rdata_q, ls_rdata_d;

  logic [2:0]  ls_num;
  logic [2:0]  rd_next;
  logic [4:0]  rd_sel;
  logic [4:0]  wr_sel;
  logic        io_stall;

  assign ls_num   = (ls_size == 2'b00) ? 3'd1 : (ls_size == 2'b01) ? 3'd2 : 3'd4;
  assign rd_next  = cnt_q + 3'd1;
  // Reads lag addresses by two edges, so the byte landing now belongs to lane cnt-1.
  assign rd_sel   = {cnt_q[1:0] - 2'd1, 3'b000};
  assign wr_sel   = {cnt_q[1:0], 3'b000};
  assign io_stall = (addr_q[17:16] == IO_ADDR_BITS) && io_buffer_full;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    num_d      = num_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    buf_d      = buf_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = mem_wr_q;
    if_valid_d = 1'b0;
    ls_valid_d = 1'b0;
    if_data_d  = if_data_q;
    ls_rdata_d = ls_rdata_q;

    case (state_q)
      StIdle: begin
        mem_a_d  = '0;
        mem_wr_d = 1'b0;
        cnt_d    = '0;
        buf_d    = '0;
        if (!clear && ls_enable) begin
          addr_d  = ls_addr;
          num_d   = ls_num;
          wdata_d = ls_wdata;
          if (ls_wr) begin
            state_d = StStore;
            if (!((ls_addr[17:16] == IO_ADDR_BITS) && io_buffer_full)) begin
              mem_a_d    = ls_addr;
              mem_wr_d   = 1'b1;
              mem_dout_d = ls_wdata[7:0];
              cnt_d      = 3'd1;
            end
          end else begin
            state_d = StLoad;
            mem_a_d = ls_addr;
          end
        end else if (!clear && if_enable) begin
          addr_d  = if_addr;
          num_d   = 3'd4;
          state_d = StIfetch;
          mem_a_d = if_addr;
        end
      end

      StIfetch, StLoad: begin
        if (clear) begin
          state_d = StIdle;
          mem_a_d = '0;
        end else begin
          cnt_d   = rd_next;
          mem_a_d = (rd_next < num_q) ? addr_q + {29'd0, rd_next} : '0;
          if (cnt_q != 3'd0) begin
            buf_d[rd_sel +: 8] = mem_din;
          end
          if (cnt_q == num_q) begin
            state_d = StCool;
            if (state_q == StIfetch) begin
              if_data_d  = buf_d;
              if_valid_d = 1'b1;
            end else begin
              ls_rdata_d = buf_d;
              ls_valid_d = 1'b1;
            end
          end
        end
      end

      // Stores ignore clear: once accepted they are committed.
      StStore: begin
        if (cnt_q == num_q) begin
          state_d    = StCool;
          mem_wr_d   = 1'b0;
          mem_a_d    = '0;
          ls_valid_d = 1'b1;
        end else if (io_stall) begin
          mem_wr_d = 1'b0;
          mem_a_d  = '0;
        end else begin
          mem_a_d    = addr_q + {29'd0, cnt_q};
          mem_wr_d   = 1'b1;
          mem_dout_d = wdata_q[wr_sel +: 8];
          cnt_d      = rd_next;
        end
      end

      StCool: begin
        state_d  = StIdle;
        mem_a_d  = '0;
        mem_wr_d = 1'b0;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      num_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      buf_q      <= '0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= 1'b0;
      if_valid_q <= 1'b0;
      ls_valid_q <= 1'b0;
      if_data_q  <= '0;
      ls_rdata_q <= '0;
    end else if (rdy) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      num_q      <= num_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      buf_q      <= buf_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      if_valid_q <= if_valid_d;
      ls_valid_q <= ls_valid_d;
      if_data_q  <= if_data_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  assign mem_a    = mem_a_q;
  assign mem_dout = mem_dout_q;
  assign mem_wr   = mem_wr_q;
  assign if_valid = if_valid_q;
  assign ls_valid = ls_valid_q;
  assign if_data  = if_data_q;
  assign ls_rdata = ls_rdata_q;

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Sits directly upstream of the instruction cache, between the single byte-wide RAM/IO port and two requesters: the ICache (32-bit instruction fetch) and the load/store buffer (LSB, 1/2/4-byte loads and stores).
- Arbitrates between the two requesters and serialises every access into little-endian byte transfers.
- Returns a one-cycle valid pulse with the assembled word, which the ICache writes into its line.

Parameters:
- IO_ADDR_BITS, 2'b11, value of addr[17:16] that marks an IO-mapped address.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; low freezes every register
- mem_din  in  8  byte returned by RAM/IO
- mem_dout  out  8  byte to write
- mem_a  out  32  byte address
- mem_wr  out  1  1 = write, 0 = read
- io_buffer_full  in  1  IO write buffer cannot accept a byte
- clear  in  1  misprediction flush
- if_enable  in  1  ICache request; held high until if_valid
- if_addr  in  32  fetch address, word aligned
- if_data  out  32  fetched instruction
- if_valid  out  1  one-cycle completion pulse
- ls_enable  in  1  LSB request; held high until ls_valid
- ls_wr  in  1  1 = store, 0 = load
- ls_size  in  2  00 = byte, 01 = half, 10/11 = word
- ls_addr  in  32  access address
- ls_wdata  in  32  store data, low bytes used
- ls_rdata  out  32  load data, zero-extended
- ls_valid  out  1  one-cycle completion pulse

Behaviour:
- Reset values: state IDLE, counter 0, mem_a 0, mem_dout 0, mem_wr 0, if_valid 0, ls_valid 0, if_data 0, ls_rdata 0.
- rdy low: no register changes, including the counter, outputs and state.
- States:
  - IDLE: may accept a request.
  - COOL: one cycle in which a valid pulse is high and no request is accepted; always goes to IDLE next. This prevents re-serving a requester whose enable drops one edge after it sees valid.
  - IFETCH, LOAD, STORE.
- Arbitration in IDLE: LSB has priority over ICache when both enables are high. Requests are sampled only in IDLE, and only when clear is low.
- Size: N = 1, 2 or 4 bytes. Byte i is at address addr+i and maps to data bits [8i+7:8i].
- Read (IFETCH or LOAD), request accepted at edge E0:
  - E0: mem_a <= addr, mem_wr = 0.
  - E1..E(N-1): mem_a <= addr+1 .. addr+N-1.
  - The RAM returns data one cycle after it sees an address, so byte i is captured from mem_din at edge E(i+2).
  - E(N+1): the last byte is captured, the valid pulse is set and the state goes to COOL.
  - Word fetch: valid visible in the cycle after E5. Byte load: after E2.
  - When no new address is needed, mem_a returns to 0.
- Store, accepted at E0:
  - E0: mem_a <= addr, mem_wr <= 1, mem_dout <= byte 0.
  - E1..E(N-1): subsequent bytes.
  - EN: mem_wr <= 0, mem_a <= 0, ls_valid <= 1, state goes to COOL.
  - Word store: valid after E4. Byte store: after E1.
- IO stores (addr[17:16] == IO_ADDR_BITS):
  - While io_buffer_full is high, no byte is issued. mem_wr is held at 0 and the counter holds.
  - Issuing resumes on the first cycle io_buffer_full is low.
  - A stall can occur before any byte and between bytes.
- Outputs:
  - if_data and ls_rdata hold their last value after the valid pulse.
  - Valid pulses last exactly one cycle.
  - At most one of if_valid and ls_valid is high in any cycle.
- clear:
  - IFETCH or LOAD in progress: abort. State goes to IDLE, mem_a <= 0, no valid pulse, partial data discarded.
  - STORE in progress: the store is committed. clear is ignored and the store completes with ls_valid.
  - clear during COOL: the valid pulse still occurs.
  - clear in IDLE: no request is accepted that cycle.
- Reset mid-operation: immediate return to the reset values, with mem_wr 0 on the next cycle.
- Address arithmetic is 32-bit and wraps modulo 2^32. No alignment check is made.

Test Plan:
- ICache fetch, if_addr = 0x0000_1000, RAM bytes 0x13, 0x05, 0x10, 0x00 -> mem_a sequence 0x1000..0x1003, if_data = 0x0010_0513, if_valid high for one cycle exactly 5 cycles after acceptance, then COOL, then IDLE.
- Simultaneous if_enable and ls_enable (load word, ls_addr = 0x2000) -> LSB served first with ls_valid. ICache is accepted in the first IDLE cycle after COOL.
- Store half, ls_addr = 0x0000_0104, ls_wdata = 0xDEAD_BEEF -> writes 0xEF@0x104 then 0xBE@0x105, mem_wr high for exactly 2 cycles, ls_valid 2 cycles after acceptance.
- IO byte store, ls_addr = 0x0003_0000, io_buffer_full high for 3 cycles -> mem_wr stays 0 for those 3 cycles, then one write of byte 0, then ls_valid.
- clear asserted 2 cycles into a word fetch -> no if_valid, state IDLE next cycle. clear asserted mid word-store -> all 4 bytes are still written and ls_valid pulses.
- Byte load at 0x0000_0007 with mem_din = 0xF0, then rdy low for 2 cycles mid-word-fetch -> ls_rdata = 0x0000_00F0. The word fetch completes 2 cycles later than nominal with correct data.
